dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the data memory: master 0 is the CPU load/store unit, master 1 the DMA/debug port.
- Each accepted request becomes exactly one single-cycle data-memory access. The block drives dm_ena/dm_r/dm_w, the eight size/sign flags, the address and the write data, all from registers.
- Read data is captured and returned with a fixed latency. Misaligned or illegal requests are rejected without touching memory.

Parameters:
- ADDR_W, 7, byte-address width forwarded to memory
- RR_INIT, 1, reset value of last-granted pointer (1 = master 0 has first priority)

Ports:
- clk  in  1  system clock, rising-edge; memory writes on falling edge
- rst_n  in  1  asynchronous active-low reset
- mN_req  in  1  request, N=0,1; held with command until mN_gnt seen
- mN_we  in  1  1 = store, 0 = load
- mN_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- mN_sext  in  1  loads only: 1 signed (lb/lh), 0 unsigned (lbu/lhu); ignored for word
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  32  store data
- mN_gnt  out  1  one-cycle pulse: command taken, access in progress
- mN_rvalid  out  1  one-cycle response pulse, reads and writes
- mN_err  out  1  qualifies mN_rvalid: request rejected
- mN_rdata  out  32  load data, valid with mN_rvalid; 0 for stores/errors
- dm_ena, dm_r, dm_w  out  1 each  memory controls
- sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag  out  1 each  one-hot access type
- dm_addr  out  ADDR_W  memory address, passed unshifted
- dm_data_in  out  32  memory write data
- dm_data_out  in  32  memory read data, combinational

Behaviour:
- Reset (async, immediate):
  - FSM to IDLE; all outputs 0.
  - Pointer = RR_INIT.
  - A write in flight is dropped, because dm_ena falls before the negedge.
- FSM states:
  - IDLE -> ACCESS when any eligible req is set at a rising edge.
  - ACCESS -> ACCESS if another eligible req exists; otherwise ACCESS -> IDLE.
- Eligibility: in ACCESS, the master currently granted is ineligible at that edge, because its req is still the one being served.
- Arbitration:
  - Round-robin; the master not last granted wins a tie.
  - The winner's command is latched at the arbitration edge.
  - The pointer updates to the winner.
- Timing (request sampled at edge t):
  - Cycle t+1: ACCESS; mN_gnt=1; memory controls valid for the whole cycle.
  - Store: committed at the mid-cycle falling edge.
  - Load: dm_data_out sampled at edge t+2 into mN_rdata.
  - Cycle t+2: mN_rvalid=1 for one cycle.
- Memory drive in ACCESS:
  - dm_ena=1; dm_r=!we; dm_w=we.
  - Exactly one flag set, per we/size/sext.
  - Outside ACCESS, all controls, flags and dm_data_in are 0.
- Alignment check, performed at latch:
  - Error if: half with addr[0]=1; word with addr[1:0]!=0; size=11.
  - On error, ACCESS still occurs with mN_gnt=1, but dm_ena=0 and all flags 0.
  - At t+2: mN_rvalid=1, mN_err=1, mN_rdata=0.
- Throughput:
  - Both masters busy: alternate grants, one access per cycle.
  - Single master: one access every 2 cycles.
- req dropped before gnt: request withdrawn; no access.
- rdata holds its value until the next mN_rvalid.

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN defined: master 0 always wins when eligible. The pointer is still maintained but ignored. Master 1 is granted only in cycles where master 0 is ineligible or idle.
- Undefined: round-robin as above.

Test Plan:
- Reset then m0 word store to addr 0x08, data 0xDEADBEEF.
  - Required: m0_gnt at t+1 with dm_w=1, sw_flag=1, dm_addr=0x08.
  - Required: m0_rvalid=1, err=0 at t+2.
- Byte 0x80 stored at addr 5, then m1 loads it:
  - lb -> rdata 0xFFFFFF80.
  - lbu -> rdata 0x00000080.
  - Each response at t+2 with lb_flag or lbu_flag set during its ACCESS.
- m0 and m1 both hold req continuously:
  - Required grants m0,m1,m0,m1 on consecutive cycles, no idle cycle.
  - With DMEM_ARB_FIXED_PRIO_EN: m0,m1,m0,m1 still, because m0 is ineligible after each grant. If m1 raises req while m0 is IDLE-pending, m0 wins.
- m0 half load at addr 0x03:
  - Required: m0_gnt, dm_ena=0 in ACCESS.
  - Required: m0_rvalid=1, m0_err=1, rdata=0.
- Illegal size 11 store from m1:
  - Required: memory contents unchanged (read back equal prior value), m1_err=1.
- rst_n asserted low mid-ACCESS of a store:
  - Required: dm_ena=0 immediately and no rvalid.
  - Required: readback shows old data; after release the first grant goes to m0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter and sequencer in front of the data memory.
//   Master 0 is the CPU load/store unit and master 1 is the DMA/debug port.
//   Each accepted request becomes one single-cycle memory access (ACCESS state).
//   The memory strobes, the one-hot access-type flags, the address and the write
//   data are all driven from registers. Read data is captured at the end of the
//   ACCESS cycle and returned one cycle after the grant. Misaligned or illegal
//   requests are granted but never touch memory, and they return an error.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   mN_req/we/size/sext      request and command, N = 0, 1; held until mN_gnt
//   mN_addr, mN_wdata        byte address, store data
//   mN_gnt                   one-cycle pulse: command taken, access in progress
//   mN_rvalid/err/rdata      one-cycle response, error qualifier, load data
//   dm_ena, dm_r, dm_w       memory controls
//   sb..lw_flag              one-hot access type
//   dm_addr, dm_data_in      memory address (unshifted) and write data
//   dm_data_out              memory read data (combinational)
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give master 0 fixed priority
// over master 1. The round-robin pointer is still updated but has no effect.

module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned RR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_sext,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_sext,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,
  output logic              dm_ena,
  output logic              dm_r,
  output logic              dm_w,
  output logic              sb_flag,
  output logic              sh_flag,
  output logic              sw_flag,
  output logic              lb_flag,
  output logic              lh_flag,
  output logic              lbu_flag,
  output logic              lhu_flag,
  output logic              lw_flag,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_data_in,
  input  logic [31:0]       dm_data_out
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e state_q, state_d;

  logic              cur_q, cur_d;          // master owning the access in flight
  logic              ptr_q, ptr_d;          // last-granted master
  logic              acc_err_q, acc_err_d;  // access in flight was rejected
  logic              acc_we_q, acc_we_d;    // access in flight is a store
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              dm_ena_q, dm_ena_d;
  logic              dm_r_q, dm_r_d;
  logic              dm_w_q, dm_w_d;
  logic [7:0]        flags_q, flags_d;      // {sb, sh, sw, lb, lh, lbu, lhu, lw}
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              elig0, elig1, any_elig, win;
  logic              sel_we, sel_sext, sel_err;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata, load_data;

  // Eligibility and arbitration. The master being served holds its req through
  // the edge that ends its ACCESS cycle, so it must not win that edge again.
  always_comb begin
    elig0    = m0_req && !(state_q == StAccess && cur_q == 1'b0);
    elig1    = m1_req && !(state_q == StAccess && cur_q == 1'b1);
    any_elig = elig0 || elig1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    win      = !elig0;
`else
    win      = (elig0 && elig1) ? !ptr_q : elig1;
`endif
  end

  // Winner's command and alignment check.
  always_comb begin
    sel_we    = win ? m1_we    : m0_we;
    sel_size  = win ? m1_size  : m0_size;
    sel_sext  = win ? m1_sext  : m0_sext;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_err   = (sel_size == 2'b11) ||
                (sel_size == 2'b01 && sel_addr[0]) ||
                (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: every edge with an eligible request starts a new ACCESS cycle.
  always_comb begin
    state_d = any_elig ? StAccess : StIdle;
  end

  // Output and datapath next values.
  always_comb begin
    cur_d     = cur_q;
    ptr_d     = ptr_q;
    acc_err_d = acc_err_q;
    acc_we_d  = acc_we_q;
    gnt_d     = 2'b00;
    rvalid_d  = 2'b00;
    err_d     = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    dm_ena_d  = 1'b0;
    dm_r_d    = 1'b0;
    dm_w_d    = 1'b0;
    flags_d   = 8'h00;
    addr_d    = '0;
    wdata_d   = 32'h0;
    load_data = 32'h0;

    if (state_d == StAccess) begin
      gnt_d[win] = 1'b1;
      cur_d      = win;
      ptr_d      = win;
      acc_err_d  = sel_err;
      acc_we_d   = sel_we;
      if (!sel_err) begin
        dm_ena_d = 1'b1;
        dm_r_d   = !sel_we;
        dm_w_d   = sel_we;
        addr_d   = sel_addr;
        wdata_d  = sel_we ? sel_wdata : 32'h0;
        case ({sel_we, sel_size})
          3'b100:  flags_d = 8'b1000_0000;
          3'b101:  flags_d = 8'b0100_0000;
          3'b110:  flags_d = 8'b0010_0000;
          3'b000:  flags_d = sel_sext ? 8'b0001_0000 : 8'b0000_0100;
          3'b001:  flags_d = sel_sext ? 8'b0000_1000 : 8'b0000_0010;
          3'b010:  flags_d = 8'b0000_0001;
          default: flags_d = 8'h00;
        endcase
      end
    end

    // Response for the access that ends at this edge.
    if (state_q == StAccess) begin
      rvalid_d[cur_q] = 1'b1;
      err_d[cur_q]    = acc_err_q;
      load_data       = (acc_err_q || acc_we_q) ? 32'h0 : dm_data_out;
      if (cur_q) begin
        rdata1_d = load_data;
      end else begin
        rdata0_d = load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q     <= 1'b0;
      ptr_q     <= (RR_INIT != 0);
      acc_err_q <= 1'b0;
      acc_we_q  <= 1'b0;
      gnt_q     <= 2'b00;
      rvalid_q  <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      dm_ena_q  <= 1'b0;
      dm_r_q    <= 1'b0;
      dm_w_q    <= 1'b0;
      flags_q   <= 8'h00;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
    end else begin
      cur_q     <= cur_d;
      ptr_q     <= ptr_d;
      acc_err_q <= acc_err_d;
      acc_we_q  <= acc_we_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      dm_ena_q  <= dm_ena_d;
      dm_r_q    <= dm_r_d;
      dm_w_q    <= dm_w_d;
      flags_q   <= flags_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign m0_gnt     = gnt_q[0];
  assign m1_gnt     = gnt_q[1];
  assign m0_rvalid  = rvalid_q[0];
  assign m1_rvalid  = rvalid_q[1];
  assign m0_err     = err_q[0];
  assign m1_err     = err_q[1];
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;
  assign dm_ena     = dm_ena_q;
  assign dm_r       = dm_r_q;
  assign dm_w       = dm_w_q;
  assign sb_flag    = flags_q[7];
  assign sh_flag    = flags_q[6];
  assign sw_flag    = flags_q[5];
  assign lb_flag    = flags_q[4];
  assign lh_flag    = flags_q[3];
  assign lbu_flag   = flags_q[2];
  assign lhu_flag   = flags_q[1];
  assign lw_flag    = flags_q[0];
  assign dm_addr    = addr_q;
  assign dm_data_in = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// multi-cycle sequences (withdrawal, reset mid-store, back-to-back grants) and a
// randomized two-master run checked against a transaction-level memory model.
module tb_dmem_arbiter;

  logic        clk, rst_n, mem_clr;
  logic        m0_req, m0_we, m0_sext, m1_req, m1_we, m1_sext;
  logic [1:0]  m0_size, m1_size;
  logic [6:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_ena, dm_r, dm_w;
  logic        sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag;
  logic [6:0]  dm_addr;
  logic [31:0] dm_data_in, dm_data_out;
  logic [7:0]  obs_flags;

  dmem_arbiter #(.ADDR_W(7), .RR_INIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dm_ena(dm_ena), .dm_r(dm_r), .dm_w(dm_w),
    .sb_flag(sb_flag), .sh_flag(sh_flag), .sw_flag(sw_flag), .lb_flag(lb_flag),
    .lh_flag(lh_flag), .lbu_flag(lbu_flag), .lhu_flag(lhu_flag), .lw_flag(lw_flag),
    .dm_addr(dm_addr), .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
  );

  assign obs_flags = {sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: byte array, stores on the falling edge, formatted reads.
  logic [7:0] phys [128];
  logic [7:0] rb0, rb1, rb2, rb3;
  assign rb0 = phys[dm_addr];
  assign rb1 = phys[dm_addr + 7'd1];
  assign rb2 = phys[dm_addr + 7'd2];
  assign rb3 = phys[dm_addr + 7'd3];

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) phys[i] <= 8'h00;
    end else if (dm_ena && dm_w) begin
      if (sb_flag || sh_flag || sw_flag) phys[dm_addr] <= dm_data_in[7:0];
      if (sh_flag || sw_flag) phys[dm_addr + 7'd1] <= dm_data_in[15:8];
      if (sw_flag) begin
        phys[dm_addr + 7'd2] <= dm_data_in[23:16];
        phys[dm_addr + 7'd3] <= dm_data_in[31:24];
      end
    end
  end

  always_comb begin
    dm_data_out = 32'h0;
    if (dm_ena && dm_r) begin
      if (lb_flag)  dm_data_out = {{24{rb0[7]}}, rb0};
      if (lbu_flag) dm_data_out = {24'h0, rb0};
      if (lh_flag)  dm_data_out = {{16{rb1[7]}}, rb1, rb0};
      if (lhu_flag) dm_data_out = {16'h0, rb1, rb0};
      if (lw_flag)  dm_data_out = {rb3, rb2, rb1, rb0};
    end
  end

  // Checking and reference model.
  int total, bad;
  int last;               // last-granted master as the model sees it
  logic [7:0] refm [128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic bad_cmd(input logic [1:0] size, input logic [6:0] addr);
    int n;
    n = 1 << size;
    return (size == 2'd3) || ((int'(addr) % n) != 0);
  endfunction

  // One-hot flag in {sb, sh, sw, lb, lh, lbu, lhu, lw} order; legal commands only.
  function automatic logic [7:0] exp_flags(input logic we, input logic [1:0] size,
                                           input logic sext);
    int idx;
    if (we) idx = 7 - int'(size);
    else if (size == 2'd2) idx = 0;
    else idx = (sext ? 4 : 2) - int'(size);
    return 8'(1 << idx);
  endfunction

  // Applies a transaction to the reference memory and returns the load result.
  task automatic ref_do(input logic we, input logic [1:0] size, input logic sext,
                        input logic [6:0] addr, input logic [31:0] wd, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    rd = 32'h0;
    v  = 32'h0;
    if (bad_cmd(size, addr)) return;
    n = 1 << size;
    for (int i = 0; i < n; i++) begin
      if (we) refm[7'(int'(addr) + i)] = wd[8*i +: 8];
      else v[8*i +: 8] = refm[7'(int'(addr) + i)];
    end
    if (!we) begin
      if (sext && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sext && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [1:0] size,
                       input logic sext, input logic [6:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_size = size; m0_sext = sext; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_size = size; m1_sext = sext; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  typedef struct {
    int          m;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  flags;
    logic        ena;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [12];

  task automatic run_vec(input vec_t v, input int k);
    logic [31:0] r;
    drive(v.m, 1'b1, v.we, v.size, v.sext, v.addr, v.wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d gnt", k), (v.m == 0) ? m0_gnt : m1_gnt, 1);
    chk($sformatf("v%0d other gnt", k), (v.m == 0) ? m1_gnt : m0_gnt, 0);
    chk($sformatf("v%0d dm_ena", k), dm_ena, v.ena);
    chk($sformatf("v%0d dm_w", k), dm_w, v.ena & v.we);
    chk($sformatf("v%0d dm_r", k), dm_r, v.ena & !v.we);
    chk($sformatf("v%0d flags", k), obs_flags, v.flags);
    if (v.ena) chk($sformatf("v%0d dm_addr", k), dm_addr, v.addr);
    if (v.ena && v.we) chk($sformatf("v%0d dm_data_in", k), dm_data_in, v.wdata);
    ref_do(v.we, v.size, v.sext, v.addr, v.wdata, r);
    last = v.m;
    drive(v.m, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h0);
    @(posedge clk); #1;
    chk($sformatf("v%0d rvalid", k), (v.m == 0) ? m0_rvalid : m1_rvalid, 1);
    chk($sformatf("v%0d err", k), (v.m == 0) ? m0_err : m1_err, v.err);
    chk($sformatf("v%0d rdata", k), (v.m == 0) ? m0_rdata : m1_rdata, v.rdata);
    chk($sformatf("v%0d idle ena", k), dm_ena, 0);
  endtask

  // Random-phase command state per master.
  logic        q_req [2];
  logic        q_we [2];
  logic [1:0]  q_size [2];
  logic        q_sext [2];
  logic [6:0]  q_addr [2];
  logic [31:0] q_wd [2];

  task automatic new_cmd(input int m);
    logic [1:0] s;
    int a;
    s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a = $urandom_range(0, 127);
    if (s != 2'd3 && $urandom_range(0, 3) != 0) a = a - (a % (1 << s));
    q_req[m]  = 1'b1;
    q_we[m]   = 1'($urandom_range(0, 1));
    q_size[m] = s;
    q_sext[m] = 1'($urandom_range(0, 1));
    q_addr[m] = 7'(a);
    q_wd[m]   = $urandom;
  endtask

  initial begin : main
    logic [31:0] refv, resp_rd, hold [2];
    logic        resp_err, e0, e1, cerr;
    logic        hold_ok [2];
    int          served, win;

    total = 0;
    bad   = 0;
    last  = 1;
    for (int i = 0; i < 128; i++) refm[i] = 8'h00;
    mem_clr = 1'b1;
    rst_n   = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h0);

    vt[0]  = '{0, 1'b1, 2'd2, 1'b0, 7'h08, 32'hDEADBEEF, 8'h20, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{0, 1'b1, 2'd0, 1'b0, 7'h05, 32'h00000080, 8'h80, 1'b1, 1'b0, 32'h0};
    vt[2]  = '{1, 1'b0, 2'd0, 1'b1, 7'h05, 32'h0,        8'h10, 1'b1, 1'b0, 32'hFFFFFF80};
    vt[3]  = '{1, 1'b0, 2'd0, 1'b0, 7'h05, 32'h0,        8'h04, 1'b1, 1'b0, 32'h00000080};
    vt[4]  = '{0, 1'b0, 2'd1, 1'b1, 7'h03, 32'h0,        8'h00, 1'b0, 1'b1, 32'h0};
    vt[5]  = '{1, 1'b1, 2'd3, 1'b0, 7'h08, 32'h12345678, 8'h00, 1'b0, 1'b1, 32'h0};
    vt[6]  = '{1, 1'b0, 2'd2, 1'b0, 7'h08, 32'h0,        8'h01, 1'b1, 1'b0, 32'hDEADBEEF};
    vt[7]  = '{0, 1'b0, 2'd1, 1'b1, 7'h0A, 32'h0,        8'h08, 1'b1, 1'b0, 32'hFFFFDEAD};
    vt[8]  = '{0, 1'b0, 2'd1, 1'b0, 7'h0A, 32'h0,        8'h02, 1'b1, 1'b0, 32'h0000DEAD};
    vt[9]  = '{0, 1'b1, 2'd2, 1'b0, 7'h0A, 32'h11111111, 8'h00, 1'b0, 1'b1, 32'h0};
    vt[10] = '{0, 1'b1, 2'd1, 1'b0, 7'h0C, 32'hAAAA1234, 8'h40, 1'b1, 1'b0, 32'h0};
    vt[11] = '{1, 1'b0, 2'd2, 1'b0, 7'h0C, 32'h0,        8'h01, 1'b1, 1'b0, 32'h00001234};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst gnt", {m1_gnt, m0_gnt}, 0);
    chk("rst rvalid", {m1_rvalid, m0_rvalid, m1_err, m0_err}, 0);
    chk("rst rdata0", m0_rdata, 0);
    chk("rst rdata1", m1_rdata, 0);
    chk("rst ctrl", {dm_ena, dm_r, dm_w, obs_flags}, 0);
    chk("rst addr/data", {25'h0, dm_addr} | dm_data_in, 0);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    @(posedge clk); #1;

    foreach (vt[k]) run_vec(vt[k], k);

    // Both request; the loser withdraws before being granted.
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 7'h08, 32'h0);
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 7'h08, 32'h0);
    @(posedge clk); #1;
    chk("wd gnt0", m0_gnt, 1);
    chk("wd gnt1", m1_gnt, 0);
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h0);
    @(posedge clk); #1;
    chk("wd gnt1 after", m1_gnt, 0);
    chk("wd idle ena", dm_ena, 0);
    chk("wd m0 rdata", m0_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("wd m1 rvalid", m1_rvalid, 0);

    // Reset asserted during the first half of a store's ACCESS cycle.
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 7'h10, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("rstmid gnt", m0_gnt, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid dm_ena", dm_ena, 0);
    chk("rstmid dm_w", dm_w, 0);
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    last  = 1;
    @(posedge clk); #1;
    chk("rstmid rvalid", {m1_rvalid, m0_rvalid}, 0);

    // Both masters hold req: alternate grants starting with m0; readback of 0x10.
    ref_do(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, refv);
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 7'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 7'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("alt%0d gnt0", i), m0_gnt, (i % 2) == 0);
      chk($sformatf("alt%0d gnt1", i), m1_gnt, (i % 2) == 1);
      if (i > 0) begin
        chk($sformatf("alt%0d rvalid", i), (i % 2 == 1) ? m0_rvalid : m1_rvalid, 1);
        chk($sformatf("alt%0d rdata", i), (i % 2 == 1) ? m0_rdata : m1_rdata, refv);
      end
    end
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h0);
    last = 1;
    @(posedge clk); #1;
    chk("alt end rdata", m1_rdata, refv);
    @(posedge clk); #1;

    // Randomized two-master traffic against the transaction model.
    served   = -1;
    resp_err = 1'b0;
    resp_rd  = 32'h0;
    for (int m = 0; m < 2; m++) begin
      q_req[m] = 1'b0; q_we[m] = 1'b0; q_size[m] = 2'd0; q_sext[m] = 1'b0;
      q_addr[m] = 7'd0; q_wd[m] = 32'h0; hold_ok[m] = 1'b0; hold[m] = 32'h0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      e0  = q_req[0] && served != 0;
      e1  = q_req[1] && served != 1;
      win = -1;
      if (e0 && e1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = (last == 0) ? 1 : 0;
`endif
      end else if (e0) win = 0;
      else if (e1) win = 1;
      chk("rnd gnt0", m0_gnt, win == 0);
      chk("rnd gnt1", m1_gnt, win == 1);
      chk("rnd rvalid0", m0_rvalid, served == 0);
      chk("rnd rvalid1", m1_rvalid, served == 1);
      if (served >= 0) begin
        chk("rnd err", (served == 0) ? m0_err : m1_err, resp_err);
        chk("rnd rdata", (served == 0) ? m0_rdata : m1_rdata, resp_rd);
        hold[served]    = resp_rd;
        hold_ok[served] = 1'b1;
      end
      if (hold_ok[0] && served != 0) chk("rnd hold0", m0_rdata, hold[0]);
      if (hold_ok[1] && served != 1) chk("rnd hold1", m1_rdata, hold[1]);
      if (win >= 0) begin
        cerr = bad_cmd(q_size[win], q_addr[win]);
        chk("rnd dm_ena", dm_ena, !cerr);
        chk("rnd dm_w", dm_w, !cerr && q_we[win]);
        chk("rnd flags", obs_flags, cerr ? 8'h00 : exp_flags(q_we[win], q_size[win], q_sext[win]));
        if (!cerr) chk("rnd dm_addr", dm_addr, q_addr[win]);
        if (!cerr && q_we[win]) chk("rnd dm_data_in", dm_data_in, q_wd[win]);
        ref_do(q_we[win], q_size[win], q_sext[win], q_addr[win], q_wd[win], resp_rd);
        resp_err = cerr;
        last     = win;
      end else begin
        chk("rnd idle ctrl", {dm_ena, dm_r, dm_w, obs_flags}, 0);
      end
      served = win;
      for (int m = 0; m < 2; m++) begin
        if (win == m) begin
          if ($urandom_range(0, 1) == 1) new_cmd(m);
          else q_req[m] = 1'b0;
        end else if (!q_req[m] && $urandom_range(0, 2) == 0) begin
          new_cmd(m);
        end
        drive(m, q_req[m], q_we[m], q_size[m], q_sext[m], q_addr[m], q_wd[m]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
